data_memory_unit: RTL and testbench
===================================

Name: data_memory_unit

Overview:
- Parametrised successor to the single-cycle word data RAM in the load/store stage.
- Adds byte/half/word access sizes, byte-lane write enables, and sign/zero extension of loads.
- Splits misaligned accesses that span two words into two RAM beats.
- Sits between the execute/memory pipeline stage and the internal data RAM, with a valid/ready request and response handshake.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words; power of two, >= 2.
- ADDR_W, 32, width of req_addr.
- INIT_FILE, "", optional $readmemh image; empty means no preload.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word).
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data; low 1/2/4 bytes are used.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts the response.
- resp_rdata  out  32  extended load data; 0 for stores.
- resp_err  out  1  access was refused (see Optional Feature); otherwise 0.

Behaviour:
- Single clock, clk. Reset is synchronous and active-high on rst.
- Reset: state goes to IDLE. req_ready=0 while rst=1, then 1 in the cycle after rst falls. resp_valid=0, resp_rdata=0, resp_err=0.
- RAM contents are not cleared by reset.
- Reset asserted mid-operation abandons the request. No RAM write occurs in any cycle where rst=1, including a pending ACC1 beat. No response is produced.
- Word index: w0 = req_addr[log2(DEPTH_WORDS)+1:2]; w1 = (w0+1) mod DEPTH_WORDS, so the top word wraps to word 0. Upper address bits are ignored.
- Offset off = addr[1:0]; byte count n = 1, 2 or 4. Data byte i maps to lane (off+i) mod 4 of w0 if off+i < 4, otherwise of w1. The access spans two words when off+n > 4.
- FSM states:
  - IDLE: req_ready=1. On req_valid & req_ready, latch all request fields and go to ACC0.
  - ACC0: access w0. Stores write only the mapped lanes; reads capture w0 into buf0. Go to ACC1 if spanning, else RESP.
  - ACC1: access w1 the same way (write lanes or capture into buf1). Go to RESP.
  - RESP: resp_valid=1 and outputs are held stable. On resp_ready go to IDLE.
- Latency: handshake at edge T. Aligned or non-spanning access: resp_valid in cycle T+2. Spanning access: resp_valid in cycle T+3.
- The unit accepts one request at a time; req_ready=0 in ACC0, ACC1 and RESP.
- Load assembly: gather n bytes from buf0/buf1 per the lane map. Byte: extend bit 7. Half: extend bit 15. Word: no extension.
- Unselected lanes are never written. Read-modify-write is not used.
- Holding resp_ready=1 permanently gives back-to-back throughput of one aligned access per 3 cycles.

Optional Feature:
- Macro DATA_MEMORY_UNIT_MISALIGN_TRAP_EN.
- Defined: spanning accesses skip ACC0/ACC1 and go IDLE -> RESP with resp_err=1 and resp_rdata=0. No RAM write takes place. resp_valid appears in cycle T+1. Non-spanning misaligned accesses (e.g. a byte at off=3, a half at off=1) still complete normally.
- Undefined: spanning accesses are split into two beats as above, and resp_err is tied to 0.

Decomposition:
- Package data_memory_pkg holds:
  - enum mem_size_e (MEM_B, MEM_H, MEM_W);
  - enum dmu_state_e (IDLE, ACC0, ACC1, RESP);
  - function lane_mask(off, size), which returns a 4-bit lane mask per word plus a span flag;
  - function load_extend(raw, size, unsigned).
- One natural sub-module, data_ram_bytewise: DEPTH_WORDS x 32 synchronous RAM with a 4-bit byte write enable and a registered read.

Test Plan:
- SW 0xDEADBEEF @0x10, then LW @0x10 -> resp_rdata=0xDEADBEEF; resp_valid at T+2 for both.
- SB 0x80 @0x13 over the 0x10 word, then LW @0x10 -> 0x80ADBEEF. LB @0x13 -> 0xFFFFFF80. LBU @0x13 -> 0x00000080.
- Words @0x20=0x44332211 and @0x24=0x88776655. LW @0x22 -> 0x66554433 at T+3. SH 0xAAAA @0x23 -> word @0x20=0xAA332211, word @0x24=0x887766AA.
- Wrap: SW 0x12345678 @0x3FE with DEPTH_WORDS=256 -> word 255 upper half = 0x5678, word 0 lower half = 0x1234.
- Backpressure: hold resp_ready=0 for 5 cycles in RESP -> outputs stable, req_ready=0. Assert rst during ACC1 of a spanning SW -> word w1 unchanged, resp_valid=0.
- With DATA_MEMORY_UNIT_MISALIGN_TRAP_EN defined: LW @0x22 -> resp_err=1 and resp_rdata=0 at T+1. SW @0x22 -> RAM unchanged.

Source files
------------

// File: rtl/data_memory_unit_pkg.sv
// Shared types and helpers for the load/store data memory unit: access sizes,
// FSM states, byte-lane mapping and load extension.
package data_memory_pkg;

  typedef enum logic [1:0] {
    MEM_B = 2'b00,
    MEM_H = 2'b01,
    MEM_W = 2'b10
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE,
    ACC0,
    ACC1,
    RESP
  } dmu_state_e;

  typedef struct packed {
    logic [3:0] mask0;  // lanes touched in the first word
    logic [3:0] mask1;  // lanes touched in the following word
    logic       span;   // access crosses into the following word
  } lane_sel_t;

  // The reserved encoding behaves as a word access.
  function automatic mem_size_e decode_size(input logic [1:0] raw);
    mem_size_e size;
    size = (raw == 2'b11) ? MEM_W : mem_size_e'(raw);
    return size;
  endfunction

  function automatic lane_sel_t lane_mask(input logic [1:0] off, input mem_size_e size);
    logic [7:0] full;
    lane_sel_t  sel;
    case (size)
      MEM_B:   full = 8'h01;
      MEM_H:   full = 8'h03;
      default: full = 8'h0F;
    endcase
    full      = full << off;
    sel.mask0 = full[3:0];
    sel.mask1 = full[7:4];
    sel.span  = |full[7:4];
    return sel;
  endfunction

  function automatic logic [31:0] lane_bits(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] raw, input mem_size_e size,
                                              input logic is_unsigned);
    logic [31:0] res;
    case (size)
      MEM_B:   res = {{24{raw[7] & ~is_unsigned}}, raw[7:0]};
      MEM_H:   res = {{16{raw[15] & ~is_unsigned}}, raw[15:0]};
      default: res = raw;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/data_memory_unit_ram.sv
// DEPTH_WORDS x 32 synchronous RAM with per-byte write enables and a registered,
// read-enabled output that holds its value while re is low.
module data_ram_bytewise #(
  parameter int    DEPTH_WORDS = 256,
  parameter string INIT_FILE   = ""
) (
  input  logic                           clk,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [3:0]                     we,
  input  logic                           re,
  input  logic [31:0]                    wdata,
  output logic [31:0]                    rdata
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  // NOTE: the array has no reset branch; clearing it would force flops instead of a RAM macro.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
    if (re) rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_memory_unit.sv
// Load/store data memory unit: byte/half/word accesses with lane enables, load
// extension and two-beat split of word-spanning accesses.
// Define DATA_MEMORY_UNIT_MISALIGN_TRAP_EN to refuse spanning accesses with resp_err.
module data_memory_unit
  import data_memory_pkg::*;
#(
  parameter int    DEPTH_WORDS = 256,
  parameter int    ADDR_W      = 32,
  parameter string INIT_FILE   = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  dmu_state_e       state_q, state_d;
  logic             write_q, write_d;
  mem_size_e        size_q, size_d;
  logic             uns_q, uns_d;
  logic [1:0]       off_q, off_d;
  logic [IDX_W-1:0] w0_q, w0_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      buf0_q, buf0_d;
  logic             err;

  lane_sel_t        sel;
  logic [IDX_W-1:0] ram_addr;
  logic [3:0]       ram_we;
  logic             ram_re;
  logic [31:0]      ram_wdata, ram_rdata;
  logic [1:0]       rot_off;
  logic [31:0]      raw0, merged, aligned;

`ifdef DATA_MEMORY_UNIT_MISALIGN_TRAP_EN
  logic      err_q, err_d;
  lane_sel_t req_sel;
  assign req_sel = lane_mask(req_addr[1:0], decode_size(req_size));
  assign err     = err_q;
`else
  assign err     = 1'b0;
`endif

  if (ADDR_W > IDX_W + 2) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[ADDR_W-1:IDX_W+2];
  end

  assign sel       = lane_mask(off_q, size_q);
  assign req_ready = (state_q == IDLE) && !rst;

  // Store data byte i lands in lane (off+i) mod 4: rotate left by off bytes.
  assign rot_off   = 2'd0 - off_q;
  assign ram_wdata = 32'({wdata_q, wdata_q} >> {rot_off, 3'b000});

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d  = state_q;
    write_d  = write_q;
    size_d   = size_q;
    uns_d    = uns_q;
    off_d    = off_q;
    w0_d     = w0_q;
    wdata_d  = wdata_q;
    buf0_d   = buf0_q;
    ram_addr = w0_q;
    ram_we   = '0;
    ram_re   = 1'b0;
`ifdef DATA_MEMORY_UNIT_MISALIGN_TRAP_EN
    err_d    = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          write_d = req_write;
          size_d  = decode_size(req_size);
          uns_d   = req_unsigned;
          off_d   = req_addr[1:0];
          w0_d    = req_addr[IDX_W+1:2];
          wdata_d = req_wdata;
          state_d = ACC0;
`ifdef DATA_MEMORY_UNIT_MISALIGN_TRAP_EN
          err_d   = req_sel.span;
          if (req_sel.span) state_d = RESP;
`endif
        end
      end
      ACC0: begin
        if (write_q) ram_we = sel.mask0;
        else         ram_re = 1'b1;
        state_d = sel.span ? ACC1 : RESP;
      end
      ACC1: begin
        ram_addr = w0_q + 1'b1;
        if (write_q) ram_we = sel.mask1;
        else         ram_re = 1'b1;
        buf0_d  = ram_rdata;  // first beat's read data is on the RAM output now
        state_d = RESP;
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst) ram_we = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Request fields are only consumed after being loaded in IDLE, so they need no reset.
  always_ff @(posedge clk) begin
    write_q <= write_d;
    size_q  <= size_d;
    uns_q   <= uns_d;
    off_q   <= off_d;
    w0_q    <= w0_d;
    wdata_q <= wdata_d;
    buf0_q  <= buf0_d;
`ifdef DATA_MEMORY_UNIT_MISALIGN_TRAP_EN
    err_q   <= err_d;
`endif
  end

  data_ram_bytewise #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .INIT_FILE  (INIT_FILE)
  ) u_ram (
    .clk  (clk),
    .addr (ram_addr),
    .we   (ram_we),
    .re   (ram_re),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  // In RESP the RAM output holds the last beat; mask0 lanes come from the first beat.
  assign raw0    = sel.span ? buf0_q : ram_rdata;
  assign merged  = (raw0 & lane_bits(sel.mask0)) | (ram_rdata & ~lane_bits(sel.mask0));
  assign aligned = 32'({merged, merged} >> {off_q, 3'b000});

  assign resp_valid = (state_q == RESP) && !rst;
  assign resp_err   = resp_valid && err;
  assign resp_rdata = (resp_valid && !write_q && !err) ? load_extend(aligned, size_q, uns_q) : '0;

endmodule

// File: tb/tb_data_memory_unit.sv
// Directed self-checking bench for data_memory_unit (DEPTH_WORDS=256), covering
// aligned, misaligned, spanning, wrap, backpressure and mid-access reset cases.
module tb_data_memory_unit;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_R = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_memory_unit #(
    .DEPTH_WORDS(256),
    .ADDR_W     (32),
    .INIT_FILE  ("")
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_size    (req_size),
    .req_unsigned(req_unsigned),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input logic wr, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wd);
    req_valid    = 1'b1;
    req_write    = wr;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wd;
  endtask

  // One complete request/response; latency counts cycles after the accepting edge.
  task automatic xact(input string tag, input logic wr, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
    int lat;
    int waitc;
    @(negedge clk);
    waitc = 0;
    while (!req_ready && waitc < 10) begin
      @(negedge clk);
      waitc++;
    end
    drive_req(wr, sz, uns, addr, wd);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid && lat < 10);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_rdata"}, resp_rdata, exp_rd);
    check({tag, "_err"}, {31'd0, resp_err}, {31'd0, exp_err});
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    logic [31:0] held;

    rst = 1'b1;
    resp_ready = 1'b1;
    drive_req(1'b0, SZ_W, 1'b0, 32'h0, 32'h0);
    req_valid = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_err", {31'd0, resp_err}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_req_ready", {31'd0, req_ready}, 32'd1);

    // Aligned word store/load
    xact("sw_10", 1'b1, SZ_W, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2);
    xact("lw_10", 1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2);

    // Byte store into the top lane, then extension variants
    xact("sb_13", 1'b1, SZ_B, 1'b0, 32'h13, 32'h00000080, 32'h0, 1'b0, 2);
    xact("lw_10b", 1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0, 2);
    xact("lb_13", 1'b0, SZ_B, 1'b0, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0, 2);
    xact("lbu_13", 1'b0, SZ_B, 1'b1, 32'h13, 32'h0, 32'h00000080, 1'b0, 2);
    xact("lh_10", 1'b0, SZ_H, 1'b0, 32'h10, 32'h0, 32'hFFFFBEEF, 1'b0, 2);
    xact("lhu_12", 1'b0, SZ_H, 1'b1, 32'h12, 32'h0, 32'h000080AD, 1'b0, 2);
    xact("lw_rsvd", 1'b0, SZ_R, 1'b0, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0, 2);
    xact("lw_alias", 1'b0, SZ_W, 1'b0, 32'h1010, 32'h0, 32'h80ADBEEF, 1'b0, 2);

    xact("sw_20", 1'b1, SZ_W, 1'b0, 32'h20, 32'h44332211, 32'h0, 1'b0, 2);
    xact("sw_24", 1'b1, SZ_W, 1'b0, 32'h24, 32'h88776655, 32'h0, 1'b0, 2);

`ifdef DATA_MEMORY_UNIT_MISALIGN_TRAP_EN
    xact("lw_22_trap", 1'b0, SZ_W, 1'b0, 32'h22, 32'h0, 32'h0, 1'b1, 1);
    xact("sh_23_trap", 1'b1, SZ_H, 1'b0, 32'h23, 32'h0000AAAA, 32'h0, 1'b1, 1);
    xact("sw_22_trap", 1'b1, SZ_W, 1'b0, 32'h22, 32'hFFFFFFFF, 32'h0, 1'b1, 1);
    xact("lw_20_kept", 1'b0, SZ_W, 1'b0, 32'h20, 32'h0, 32'h44332211, 1'b0, 2);
    xact("lw_24_kept", 1'b0, SZ_W, 1'b0, 32'h24, 32'h0, 32'h88776655, 1'b0, 2);
    xact("lh_21", 1'b0, SZ_H, 1'b0, 32'h21, 32'h0, 32'h00003322, 1'b0, 2);
    xact("lb_23", 1'b0, SZ_B, 1'b0, 32'h23, 32'h0, 32'h00000044, 1'b0, 2);
    xact("sw_3fe_trap", 1'b1, SZ_W, 1'b0, 32'h3FE, 32'h12345678, 32'h0, 1'b1, 1);
`else
    xact("lw_22_span", 1'b0, SZ_W, 1'b0, 32'h22, 32'h0, 32'h66554433, 1'b0, 3);
    xact("sh_23_span", 1'b1, SZ_H, 1'b0, 32'h23, 32'h0000AAAA, 32'h0, 1'b0, 3);
    xact("lw_20_after", 1'b0, SZ_W, 1'b0, 32'h20, 32'h0, 32'hAA332211, 1'b0, 2);
    xact("lw_24_after", 1'b0, SZ_W, 1'b0, 32'h24, 32'h0, 32'h887766AA, 1'b0, 2);
    xact("lh_21", 1'b0, SZ_H, 1'b0, 32'h21, 32'h0, 32'h00003322, 1'b0, 2);
    xact("lb_23", 1'b0, SZ_B, 1'b0, 32'h23, 32'h0, 32'hFFFFFFAA, 1'b0, 2);

    // Spanning store across the top word wraps to word 0
    xact("sw_3fe_wrap", 1'b1, SZ_W, 1'b0, 32'h3FE, 32'h12345678, 32'h0, 1'b0, 3);
    xact("lhu_3fe", 1'b0, SZ_H, 1'b1, 32'h3FE, 32'h0, 32'h00005678, 1'b0, 2);
    xact("lhu_000", 1'b0, SZ_H, 1'b1, 32'h000, 32'h0, 32'h00001234, 1'b0, 2);
    xact("lw_3fe_wrap", 1'b0, SZ_W, 1'b0, 32'h3FE, 32'h0, 32'h12345678, 1'b0, 3);
`endif

    // Backpressure: response held for 5 cycles
    resp_ready = 1'b0;
    @(negedge clk);
    drive_req(1'b0, SZ_W, 1'b0, 32'h10, 32'h0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid && lat < 10);
    check("bp_lat", 32'(lat), 32'd2);
    check("bp_rdata", resp_rdata, 32'h80ADBEEF);
    held = 32'h80ADBEEF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_valid", {31'd0, resp_valid}, 32'd1);
      check("bp_hold_rdata", resp_rdata, held);
      check("bp_hold_ready", {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_release_valid", {31'd0, resp_valid}, 32'd0);
    check("bp_release_ready", {31'd0, req_ready}, 32'd1);

`ifndef DATA_MEMORY_UNIT_MISALIGN_TRAP_EN
    // Reset during the second beat of a spanning store
    xact("sw_28", 1'b1, SZ_W, 1'b0, 32'h28, 32'h11111111, 32'h0, 1'b0, 2);
    @(negedge clk);
    drive_req(1'b1, SZ_W, 1'b0, 32'h26, 32'hCAFEF00D);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("acc1_rst_valid", {31'd0, resp_valid}, 32'd0);
    check("acc1_rst_ready", {31'd0, req_ready}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("acc1_after_valid", {31'd0, resp_valid}, 32'd0);
    check("acc1_after_ready", {31'd0, req_ready}, 32'd1);
    xact("lw_28_kept", 1'b0, SZ_W, 1'b0, 32'h28, 32'h0, 32'h11111111, 1'b0, 2);
    xact("lw_24_acc0", 1'b0, SZ_W, 1'b0, 32'h24, 32'h0, 32'hF00D66AA, 1'b0, 2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
